parallel_to_serial_16bit_4_stages: RTL and testbench

Converts a parallel frame of four 16-bit tap words back into a serial sample stream, one word per accepted cycle, with valid/ready handshakes on both sides. It is the inverse of the 4-stage tap delay line in the D_CFIR path. It emits taps oldest-first (P4 … P1), so a 4-stage delay line fed with its output reproduces Q1=P1 … Q4=P4. It sits between the beamforming weight/tap staging logic and any serial consumer (delay line, DAC interface, test capture).

---
 rtl/p2s_pkg.sv | 13 +
 rtl/p2s_ctrl.sv | 82 ++++++++
 rtl/parallel_to_serial_16bit_4_stages.sv | 59 +++++
 tb/tb_parallel_to_serial_16bit_4_stages.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared constants and state encoding for the parallel-to-serial tap unroller.
package p2s_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N_STAGES = 4;
  localparam int unsigned CNT_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/p2s_ctrl.sv
// Frame sequencer: tracks the word index, owns the output handshake flags and
// issues load/shift strobes to the datapath.
module p2s_ctrl
  import p2s_pkg::*;
#(
  parameter int unsigned N  = N_STAGES,
  parameter int unsigned CW = CNT_W
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          load_valid,
  input  logic          dout_ready,
  output logic          load_ready,
  output logic          load_en_c,
  output logic          shift_en_c,
  output logic [CW-1:0] cnt,
  output logic          dout_valid,
  output logic          last
);

  state_t        state, state_n;
  logic [CW-1:0] cnt_n;
  logic          valid_n;
  logic          last_n;
  logic          at_end;

  assign at_end = (state == SHIFT) && (cnt == CW'(N - 1));

  // Combinational so a frame can be accepted in the same cycle the final word leaves.
  assign load_ready = !Reset && ((state == IDLE) || (at_end && dout_ready));
  assign load_en_c  = load_valid && load_ready;
  assign shift_en_c = (state == SHIFT) && dout_ready && !at_end;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dout_valid <= 1'b0;
      last       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout_valid <= valid_n;
      last       <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = dout_valid;
    last_n  = last;
    unique case (state)
      IDLE: begin
        if (load_en_c) begin
          state_n = SHIFT;
          cnt_n   = '0;
          valid_n = 1'b1;
          last_n  = 1'b0;
        end
      end
      SHIFT: begin
        if (shift_en_c) begin
          cnt_n  = cnt + CW'(1);
          last_n = (cnt == CW'(N - 2));
        end else if (at_end && dout_ready) begin
          cnt_n  = '0;
          last_n = 1'b0;
          // Without a waiting frame the stream drains back to idle.
          if (!load_en_c) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/parallel_to_serial_16bit_4_stages.sv
// Unrolls a four-word tap frame into a serial stream, oldest tap (P4) first.
module parallel_to_serial_16bit_4_stages
  import p2s_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] P1,
  input  logic [DATA_W-1:0] P2,
  input  logic [DATA_W-1:0] P3,
  input  logic [DATA_W-1:0] P4,
  input  logic              load_valid,
  output logic              load_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              last
);

  logic [DATA_W-1:0] hold [N_STAGES];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_idx;
  logic              load_en_c;
  logic              shift_en_c;

  p2s_ctrl #(
    .N  (N_STAGES),
    .CW (CNT_W)
  ) u_ctrl (
    .CLK        (CLK),
    .Reset      (Reset),
    .load_valid (load_valid),
    .dout_ready (dout_ready),
    .load_ready (load_ready),
    .load_en_c  (load_en_c),
    .shift_en_c (shift_en_c),
    .cnt        (cnt),
    .dout_valid (dout_valid),
    .last       (last)
  );

  assign next_idx = cnt + CNT_W'(1);

  // Holding registers are stored in emission order: index 0 is the oldest tap.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(N_STAGES); i++) hold[i] <= '0;
      dout <= '0;
    end else if (load_en_c) begin
      hold[0] <= P4;
      hold[1] <= P3;
      hold[2] <= P2;
      hold[3] <= P1;
      dout    <= P4;
    end else if (shift_en_c) begin
      dout <= hold[next_idx];
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_16bit_4_stages.sv
// Directed and streaming checks for the tap-frame parallel-to-serial unit.
module tb_parallel_to_serial_16bit_4_stages;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] P1, P2, P3, P4;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        last;

  int n_checks = 0;
  int n_fail   = 0;

  parallel_to_serial_16bit_4_stages dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .P1         (P1),
    .P2         (P2),
    .P3         (P3),
    .P4         (P4),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .last       (last)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic set_p(input logic [15:0] a, b, c, d);
    P1 = a; P2 = b; P3 = c; P4 = d;
  endtask

  // Present a frame while idle and let it be captured on the next edge.
  task automatic load_frame(input string tag, input logic [15:0] a, b, c, d);
    @(negedge CLK);
    set_p(a, b, c, d);
    load_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    check({tag, "_ld_rdy"}, 16'(load_ready), 16'd1);
    @(posedge CLK);
  endtask

  // Walk one frame out, optionally stalling at word stall_k and pulsing a
  // stray load at word pulse_k; finishes with an idle check.
  task automatic emit(input string tag, input logic [15:0] e0, e1, e2, e3,
                      input int stall_k, input int stall_n, input int pulse_k);
    logic [15:0] exp [4];
    exp = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge CLK);
          load_valid = 1'b0;
          dout_ready = 1'b0;
          #1;
          check({tag, "_stall_dout"},  dout, exp[k]);
          check({tag, "_stall_vld"},   16'(dout_valid), 16'd1);
          check({tag, "_stall_last"},  16'(last), 16'(k == 3));
          check({tag, "_stall_ldrdy"}, 16'(load_ready), 16'd0);
        end
      end
      @(negedge CLK);
      dout_ready = 1'b1;
      if (k == pulse_k) begin
        load_valid = 1'b1;
        set_p(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
      end else begin
        load_valid = 1'b0;
      end
      #1;
      check({tag, "_dout"},  dout, exp[k]);
      check({tag, "_vld"},   16'(dout_valid), 16'd1);
      check({tag, "_last"},  16'(last), 16'(k == 3));
      check({tag, "_ldrdy"}, 16'(load_ready), 16'(k == 3));
      @(posedge CLK);
    end
    @(negedge CLK);
    load_valid = 1'b0;
    #1;
    check({tag, "_idle_vld"},   16'(dout_valid), 16'd0);
    check({tag, "_idle_last"},  16'(last), 16'd0);
    check({tag, "_idle_ldrdy"}, 16'(load_ready), 16'd1);
    check({tag, "_idle_dout"},  dout, exp[3]);
  endtask

  logic [15:0] fp [100][4];
  logic [15:0] q1, q2, q3, q4, od;
  int          load_cnt, words, cyc;
  logic        lt, ot;

  initial begin
    Reset      = 1'b1;
    load_valid = 1'b0;
    dout_ready = 1'b0;
    set_p(16'h0, 16'h0, 16'h0, 16'h0);

    @(negedge CLK);
    #1;
    check("rst_dout",  dout, 16'h0000);
    check("rst_vld",   16'(dout_valid), 16'd0);
    check("rst_last",  16'(last), 16'd0);
    check("rst_ldrdy", 16'(load_ready), 16'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // Single frame, ready held high.
    load_frame("f1", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    emit("f1", 16'h0004, 16'h0003, 16'h0002, 16'h0001, -1, 0, -1);

    // Back-to-back frames with no bubble between them.
    @(negedge CLK);
    set_p(16'hA001, 16'hA002, 16'hA003, 16'hA004);
    load_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    check("b2b_ld_rdy", 16'(load_ready), 16'd1);
    @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      @(negedge CLK);
      if (i == 0) set_p(16'hB001, 16'hB002, 16'hB003, 16'hB004);
      if (i >= 4) load_valid = 1'b0;
      #1;
      e = (i < 4) ? 16'hA004 - 16'(i) : 16'hB004 - 16'(i - 4);
      check("b2b_dout",  dout, e);
      check("b2b_vld",   16'(dout_valid), 16'd1);
      check("b2b_last",  16'(last), 16'((i % 4) == 3));
      check("b2b_ldrdy", 16'(load_ready), 16'((i % 4) == 3));
      @(posedge CLK);
    end
    @(negedge CLK);
    #1;
    check("b2b_idle_vld", 16'(dout_valid), 16'd0);

    // Downstream stall of three cycles on the second word.
    load_frame("stl", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    emit("stl", 16'h4444, 16'h3333, 16'h2222, 16'h1111, 1, 3, -1);

    // Stray load request mid-frame must be ignored.
    load_frame("ign", 16'h5001, 16'h5002, 16'h5003, 16'h5004);
    emit("ign", 16'h5004, 16'h5003, 16'h5002, 16'h5001, -1, 0, 1);

    // Random frames through a 4-stage delay line with random back-pressure.
    for (int f = 0; f < 100; f++)
      for (int w = 0; w < 4; w++) fp[f][w] = 16'($urandom);
    q1 = '0; q2 = '0; q3 = '0; q4 = '0;
    load_cnt = 0; words = 0; cyc = 0;
    while (words < 400 && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
      dout_ready = ($urandom_range(0, 3) != 0);
      if (load_cnt < 100) begin
        load_valid = 1'b1;
        set_p(fp[load_cnt][0], fp[load_cnt][1], fp[load_cnt][2], fp[load_cnt][3]);
      end else begin
        load_valid = 1'b0;
      end
      #1;
      lt = load_valid && load_ready;
      ot = dout_valid && dout_ready;
      od = dout;
      @(posedge CLK);
      if (lt) load_cnt++;
      if (ot) begin
        q4 = q3; q3 = q2; q2 = q1; q1 = od;
        words++;
        if (words % 4 == 0) begin
          check("dl_q1", q1, fp[words / 4 - 1][0]);
          check("dl_q2", q2, fp[words / 4 - 1][1]);
          check("dl_q3", q3, fp[words / 4 - 1][2]);
          check("dl_q4", q4, fp[words / 4 - 1][3]);
        end
      end
    end
    if (words < 400) check("rand_timeout", 16'(words), 16'd400);
    @(negedge CLK);
    load_valid = 1'b0;
    dout_ready = 1'b1;

    // Asynchronous reset while the third word is pending.
    load_frame("mr", 16'hC001, 16'hC002, 16'hC003, 16'hC004);
    @(negedge CLK);
    load_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("mr_pre_dout", dout, 16'hC002);
    #1;
    Reset = 1'b1;
    #1;
    check("mr_dout",  dout, 16'h0000);
    check("mr_vld",   16'(dout_valid), 16'd0);
    check("mr_last",  16'(last), 16'd0);
    check("mr_ldrdy", 16'(load_ready), 16'd0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("mr_post_ldrdy", 16'(load_ready), 16'd1);
    load_frame("pr", 16'h00FF, 16'h0FF0, 16'hFF00, 16'h0F00);
    emit("pr", 16'h0F00, 16'hFF00, 16'h0FF0, 16'h00FF, -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
